// File: rtl/vlc_bit_packer.sv
// Packs right-aligned variable-length codes into an MSB-first stream of 32-bit words.
// Optional byte counter on byte_count is built only when VLC_BIT_PACKER_BYTE_COUNT_EN is defined.
module vlc_bit_packer #(
   parameter logic PAD_BIT = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        flush,
   input  logic [31:0] code,
   input  logic [5:0]  code_length,
   output logic        word_valid,
   output logic [31:0] word,
   output logic        flush_done,
   output logic        busy,
   output logic        protocol_error,
   output logic [31:0] byte_count
);

   typedef enum logic {
      ST_RUN,
      ST_FLUSH_TAIL
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [4:0]  fill_q, fill_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;
   logic        flush_done_q, flush_done_d;
   logic        perr_q, perr_d;

   logic [5:0]  len;
   logic [31:0] masked;
   logic [6:0]  shift_up;
   logic [63:0] placed;
   logic [63:0] acc_app;
   logic [6:0]  fill_sum;
   logic [63:0] acc_mid;
   logic [6:0]  fill_mid;
   logic        emitted;

   // Keeps the first `valid_bits` MSBs of data and fills the rest with PAD_BIT.
   function automatic logic [31:0] pad_word(input logic [31:0] data, input logic [4:0] valid_bits);
      logic [31:0] keep;
      keep = ~(32'hFFFF_FFFF >> valid_bits);
      return (data & keep) | ({32{PAD_BIT}} & ~keep);
   endfunction

   // Left-justify the masked code against bit 63, then slide it down past the bits already held.
   always_comb begin
      len      = (code_length > 6'd32) ? 6'd32 : code_length;
      masked   = len[5] ? code : (code & ((32'h1 << len[4:0]) - 32'h1));
      shift_up = 7'd64 - {1'b0, len};
      placed   = ({32'h0, masked} << shift_up) >> fill_q;
      acc_app  = acc_q | placed;
      fill_sum = {2'b00, fill_q} + {1'b0, len};
   end

   // NOTE: every signal written below gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      fill_d       = fill_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      flush_done_d = 1'b0;
      perr_d       = perr_q;
      acc_mid      = acc_q;
      fill_mid     = {2'b00, fill_q};
      emitted      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (enable) begin
               acc_mid  = acc_app;
               fill_mid = fill_sum;
               if (fill_sum >= 7'd32) begin
                  emitted      = 1'b1;
                  word_valid_d = 1'b1;
                  word_d       = acc_app[63:32];
                  acc_mid      = acc_app << 32;
                  fill_mid     = fill_sum - 7'd32;
               end
            end
            if (flush) begin
               // Only one word can leave per cycle, so a leftover after a full word waits a cycle.
               if (emitted && (fill_mid != 7'd0)) begin
                  state_d = ST_FLUSH_TAIL;
               end else begin
                  flush_done_d = 1'b1;
                  if (!emitted && (fill_mid != 7'd0)) begin
                     word_valid_d = 1'b1;
                     word_d       = pad_word(acc_mid[63:32], fill_mid[4:0]);
                  end
                  acc_mid  = '0;
                  fill_mid = '0;
               end
            end
            acc_d  = acc_mid;
            fill_d = fill_mid[4:0];
         end
         ST_FLUSH_TAIL: begin
            word_valid_d = 1'b1;
            flush_done_d = 1'b1;
            word_d       = pad_word(acc_q[63:32], fill_q);
            acc_d        = '0;
            fill_d       = '0;
            state_d      = ST_RUN;
            if (enable || flush) begin
               perr_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= ST_RUN;
         acc_q        <= '0;
         fill_q       <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         flush_done_q <= 1'b0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         flush_done_q <= flush_done_d;
         perr_q       <= perr_d;
      end
   end

`ifdef VLC_BIT_PACKER_BYTE_COUNT_EN
   logic [31:0] byte_count_q, byte_count_d;

   always_comb begin
      byte_count_d = byte_count_q;
      if (word_valid_d) begin
         byte_count_d = byte_count_q + 32'd4;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         byte_count_q <= '0;
      end else begin
         byte_count_q <= byte_count_d;
      end
   end

   assign byte_count = byte_count_q;
`else
   assign byte_count = 32'h0;
`endif

   assign word_valid     = word_valid_q;
   assign word           = word_q;
   assign flush_done     = flush_done_q;
   assign busy           = (state_q == ST_FLUSH_TAIL);
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer: reset, packing, straddle, flushes, simultaneous enable+flush.
// Expected byte_count follows whether VLC_BIT_PACKER_BYTE_COUNT_EN is defined.
module tb_vlc_bit_packer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        flush;
   logic [31:0] code;
   logic [5:0]  code_length;
   logic        word_valid;
   logic [31:0] word;
   logic        flush_done;
   logic        busy;
   logic        protocol_error;
   logic [31:0] byte_count;

   int checks   = 0;
   int failures = 0;

`ifdef VLC_BIT_PACKER_BYTE_COUNT_EN
   localparam bit BC_EN = 1'b1;
`else
   localparam bit BC_EN = 1'b0;
`endif

   vlc_bit_packer dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable         (enable),
      .flush          (flush),
      .code           (code),
      .code_length    (code_length),
      .word_valid     (word_valid),
      .word           (word),
      .flush_done     (flush_done),
      .busy           (busy),
      .protocol_error (protocol_error),
      .byte_count     (byte_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one input cycle; return just after the capturing edge so outputs show its result.
   task automatic step(input logic en, input logic fl, input logic [31:0] c, input logic [5:0] l);
      @(negedge clock);
      enable      = en;
      flush       = fl;
      code        = c;
      code_length = l;
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic wv, input logic [31:0] w,
                             input logic fd, input logic bz);
      check({tag, ".word_valid"}, {31'h0, word_valid}, {31'h0, wv});
      if (wv) check({tag, ".word"}, word, w);
      check({tag, ".flush_done"}, {31'h0, flush_done}, {31'h0, fd});
      check({tag, ".busy"}, {31'h0, busy}, {31'h0, bz});
   endtask

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b0;
      flush       = 1'b0;
      code        = '0;
      code_length = '0;

      // Reset held two cycles with enable active and random code.
      step(1'b1, 1'b0, $urandom, 6'd20);
      step(1'b1, 1'b0, $urandom, 6'd20);
      expect_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
      check("reset.word", word, 32'h0);
      check("reset.protocol_error", {31'h0, protocol_error}, 32'h0);
      check("reset.byte_count", byte_count, 32'h0);
      reset_n = 1'b1;
      step(1'b0, 1'b0, 32'h0, 6'd0);
      expect_out("idle", 1'b0, 32'h0, 1'b0, 1'b0);

      // Eight nibbles of 0xF form one full word only after the eighth.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b0, 32'hF, 6'd4);
         check("pack.no_word", {31'h0, word_valid}, 32'h0);
      end
      step(1'b1, 1'b0, 32'hF, 6'd4);
      expect_out("pack.eighth", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 6'd0);
      check("pack.after_valid", {31'h0, word_valid}, 32'h0);
      check("pack.word_hold", word, 32'hFFFF_FFFF);

      // One bit, then a 32-bit code straddling the word boundary, then flush.
      step(1'b1, 1'b0, 32'h1, 6'd1);
      check("straddle.first", {31'h0, word_valid}, 32'h0);
      step(1'b1, 1'b0, 32'hABCD_EF01, 6'd32);
      expect_out("straddle.word", 1'b1, 32'hD5E6_F780, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0, 6'd0);
      expect_out("straddle.flush", 1'b1, 32'h8000_0000, 1'b1, 1'b0);
      check("byte_count.after_straddle", byte_count, BC_EN ? 32'd12 : 32'd0);

      // Flush with nothing buffered.
      step(1'b0, 1'b1, 32'h0, 6'd0);
      expect_out("empty_flush", 1'b0, 32'h0, 1'b1, 1'b0);
      check("empty_flush.word_hold", word, 32'h8000_0000);

      // Code bits above the length are ignored; zero length is a data no-op.
      step(1'b1, 1'b0, 32'hFFFF_FFFF, 6'd4);
      step(1'b1, 1'b0, 32'hFFFF_FFFF, 6'd0);
      check("len0.no_word", {31'h0, word_valid}, 32'h0);
      step(1'b1, 1'b0, 32'h0, 6'd28);
      expect_out("mask", 1'b1, 32'hF000_0000, 1'b0, 1'b0);

      // Lengths above 32 saturate to 32.
      step(1'b1, 1'b0, 32'h1234_5678, 6'd45);
      expect_out("saturate", 1'b1, 32'h1234_5678, 1'b0, 1'b0);

      // Enable+flush without overflow: padded word and flush_done together.
      step(1'b1, 1'b1, 32'h3, 6'd2);
      expect_out("enflush.small", 1'b1, 32'hC000_0000, 1'b1, 1'b0);

      // Enable+flush landing exactly on 32 bits: one word with flush_done, no tail.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'hF, 6'd4);
      step(1'b1, 1'b1, 32'hA5, 6'd8);
      expect_out("enflush.exact", 1'b1, 32'hFFFF_FFA5, 1'b1, 1'b0);

      // Enable+flush with overflow: full word then padded tail; input during busy is an error.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'hF, 6'd4);
      step(1'b1, 1'b1, 32'hFF, 6'd8);
      expect_out("simul.k1", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      check("simul.k1.protocol_error", {31'h0, protocol_error}, 32'h0);
      step(1'b1, 1'b0, 32'h5555_5555, 6'd16);
      expect_out("simul.k2", 1'b1, 32'hF000_0000, 1'b1, 1'b0);
      check("simul.k2.protocol_error", {31'h0, protocol_error}, 32'h1);
      // The input seen while busy was dropped, so nothing is left to flush.
      step(1'b0, 1'b1, 32'h0, 6'd0);
      expect_out("simul.dropped", 1'b0, 32'h0, 1'b1, 1'b0);
      check("simul.sticky", {31'h0, protocol_error}, 32'h1);

      // Reset discards partial bits and clears the sticky error and counter.
      step(1'b1, 1'b0, 32'hF, 6'd4);
      reset_n = 1'b0;
      step(1'b0, 1'b0, 32'h0, 6'd0);
      reset_n = 1'b1;
      check("rst2.protocol_error", {31'h0, protocol_error}, 32'h0);
      check("rst2.byte_count", byte_count, 32'h0);
      step(1'b0, 1'b1, 32'h0, 6'd0);
      expect_out("rst2.flush", 1'b0, 32'h0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
